barker_tx: RTL and testbench
============================

# barker_tx

Barker-11 spreading transmitter: the source end of the 1-bit oversampled AXI-Stream link that feeds the Barker correlator.
- Accepts one data bit per handshake and spreads it into the 11-chip Barker code: true code for bit 1, inverted code for bit 0.
- Repeats each chip for OVERSAMPLE consecutive output samples.
- Drives the correlator input stream in the datapath, and also serves as its bench stimulus generator.

## Interface
Parameters:
- OVERSAMPLE, 4, number of output samples per chip; legal range 2..16.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_s_tvalid  in  1  input data bit valid.
- o_s_tready  out  1  transmitter accepts the input bit this cycle.
- i_s_tdata  in  1  data bit to spread.
- o_m_tvalid  out  1  output sample valid.
- i_m_tready  in  1  downstream accepts the sample.
- o_m_tdata  out  1  chip value of the current sample.
- o_m_tuser  out  1  1 on every sample of chip index 10, i.e. the first chip of a symbol.

## Operation
- The code is 11'b11100010010 and is sent MSB first: chip 10 first, chip 0 last.
- Chip value = code[idx] XNOR data bit. Bit 1 sends the code as-is; bit 0 sends its complement.
- State machine: IDLE and SEND.
  - IDLE: o_m_tvalid=0, o_s_tready=1.
  - IDLE -> SEND when i_s_tvalid is high. The bit is latched, chip_idx is set to 10 and samp_cnt to 0.
  - SEND: o_m_tvalid=1. Each output handshake (o_m_tvalid & i_m_tready) increments samp_cnt.
    - When samp_cnt reaches OVERSAMPLE-1, samp_cnt wraps to 0 and chip_idx decrements.
  - Last sample is chip_idx==0 with samp_cnt==OVERSAMPLE-1.
- o_s_tready in SEND = last sample & i_m_tready.
  - If i_s_tvalid is high on that cycle, the next symbol is loaded and the machine stays in SEND. Symbols run back-to-back with no bubble.
  - Otherwise the machine returns to IDLE.
- Held output: o_m_tdata and o_m_tuser stay stable while o_m_tvalid=1 and i_m_tready=0, as AXI-Stream requires.
- Counter widths:
  - chip_idx is 4 bits and never leaves 10..0.
  - samp_cnt is $clog2(OVERSAMPLE) bits.
- Reset:
  - Asserting i_rst at any time, including mid-symbol, clears every register and drops the partial symbol.
  - Reset values: state=IDLE, o_m_tvalid=0, o_m_tdata=0, o_m_tuser=0.
  - o_s_tready is forced 0 while i_rst is high and is 1 in the first cycle after release.

## Timing
- Latency: input handshake at edge N gives o_m_tvalid=1 with the first sample of chip 10 after edge N.
- All outputs except o_s_tready come from registers.
- o_s_tready is combinational from state, the counters and i_m_tready.
- One symbol = 11*OVERSAMPLE output handshakes: 44 at the default.
- Full throughput with i_m_tready tied to 1: one symbol every 44 cycles, with o_m_tvalid continuously high.
- Stall of any length: the counters freeze and the output holds.

## Configuration
- BARKER_TX_IDLE_FILL_EN defined:
  - IDLE drives o_m_tvalid=1, o_m_tdata=0, o_m_tuser=0. This fill stream keeps the correlator fed with no-correlation samples.
  - Each fill sample is a one-sample unit. o_s_tready in IDLE = i_m_tready, so a new symbol starts only on the cycle the current fill sample is accepted.
  - A fill sample is never replaced while stalled.
- BARKER_TX_IDLE_FILL_EN undefined: IDLE drives o_m_tvalid=0, as in the Operation section.

## Structure
- Package barker_pkg holds:
  - BARKER_LEN=11.
  - BARKER_CODE=11'b11100010010.
  - typedef enum {IDLE, SEND} barker_tx_state_t.
- The correlator and the monitors share this package.
- One sub-module: barker_chip_cnt. It holds samp_cnt and chip_idx and produces chip_last and sym_last. The top holds the state machine, the data latch and the handshake logic.

## Test plan
- Reset mid-symbol: assert i_rst after 20 samples. Outputs go to 0 asynchronously, and after release the next symbol restarts at chip 10.
- Single bit 1, i_m_tready=1: 44 samples 1111 1111 1111 0000 0000 0000 1111 0000 0000 1111 0000. o_m_tuser is 1 on samples 0..3 only, and o_m_tvalid drops after sample 43.
- Single bit 0: the exact complement of the bit-1 sequence. o_m_tuser is unchanged.
- Back-to-back bits 1,0,1 with i_s_tvalid always high: 132 consecutive valid samples. o_s_tready pulses on cycles 0, 44 and 88 relative to the first handshake.
- Random i_m_tready with 1..10-cycle toggles: o_m_tdata and o_m_tuser hold while stalled, and a 4x-majority decode of 128 random bits matches the input. Correlator tuser=1 occurs exactly for bit-1 symbols.
- BARKER_TX_IDLE_FILL_EN defined, no input for 10 cycles: o_m_tvalid=1 and o_m_tdata=0 throughout. A bit 1 is then accepted on a fill handshake and chip 10 follows on the next cycle.

Source files
------------

// File: rtl/barker_pkg.sv
// Shared Barker-11 definitions for the transmitter, correlator and monitors.
package barker_pkg;

  localparam int          BARKER_LEN  = 11;
  localparam logic [10:0] BARKER_CODE = 11'b11100010010;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } barker_tx_state_t;

  // A data bit of 1 sends the code unchanged, a 0 sends its complement.
  function automatic logic chip_val(input logic [3:0] idx, input logic data);
    return ~(BARKER_CODE[idx] ^ data);
  endfunction

endpackage

// File: rtl/barker_tx_if.sv
// Input bit stream and oversampled chip stream of the Barker transmitter.
interface barker_tx_if;

  logic i_s_tvalid;
  logic o_s_tready;
  logic i_s_tdata;
  logic o_m_tvalid;
  logic i_m_tready;
  logic o_m_tdata;
  logic o_m_tuser;

  modport master (
    input  i_s_tvalid, i_s_tdata, i_m_tready,
    output o_s_tready, o_m_tvalid, o_m_tdata, o_m_tuser
  );

  modport slave (
    output i_s_tvalid, i_s_tdata, i_m_tready,
    input  o_s_tready, o_m_tvalid, o_m_tdata, o_m_tuser
  );

endinterface

// File: rtl/barker_chip_cnt.sv
// Sample-within-chip and chip-within-symbol counters for the Barker transmitter.
module barker_chip_cnt #(
  parameter int OVERSAMPLE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [3:0] o_chip_idx,
  output logic       o_chip_last,
  output logic       o_sym_last
);

  localparam int            SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SAMP_MAX = SW'(OVERSAMPLE - 1);

  logic [SW-1:0] samp_cnt_d, samp_cnt_q;
  logic [3:0]    chip_idx_d, chip_idx_q;

  assign o_chip_idx  = chip_idx_q;
  assign o_chip_last = (samp_cnt_q == SAMP_MAX);
  assign o_sym_last  = o_chip_last && (chip_idx_q == 4'd0);

  // Load wins over advance so a back-to-back symbol restarts at chip 10.
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    chip_idx_d = chip_idx_q;
    if (i_load) begin
      samp_cnt_d = '0;
      chip_idx_d = 4'd10;
    end else if (i_adv) begin
      if (o_chip_last) begin
        samp_cnt_d = '0;
        chip_idx_d = o_sym_last ? 4'd0 : (chip_idx_q - 4'd1);
      end else begin
        samp_cnt_d = samp_cnt_q + SW'(1);
      end
    end else begin
      samp_cnt_d = samp_cnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      samp_cnt_q <= '0;
      chip_idx_q <= 4'd0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      chip_idx_q <= chip_idx_d;
    end
  end

endmodule

// File: rtl/barker_tx.sv
// Barker-11 spreading transmitter: one input bit becomes 11*OVERSAMPLE output samples.
// Define BARKER_TX_IDLE_FILL_EN to stream zero-valued fill samples while idle.
module barker_tx
  import barker_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  barker_tx_if.master bus
);

`ifdef BARKER_TX_IDLE_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  barker_tx_state_t state_d, state_q;
  logic bit_d, bit_q;
  logic m_tvalid_d, m_tvalid_q;
  logic m_tdata_d, m_tdata_q;
  logic m_tuser_d, m_tuser_q;

  logic       s_tready_s, s_hs_s, m_hs_s, load_s, adv_s;
  logic       chip_last_s, sym_last_s;
  logic [3:0] chip_idx_s;

  barker_chip_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (load_s),
    .i_adv       (adv_s),
    .o_chip_idx  (chip_idx_s),
    .o_chip_last (chip_last_s),
    .o_sym_last  (sym_last_s)
  );

  assign m_hs_s = m_tvalid_q & bus.i_m_tready;
  assign s_hs_s = bus.i_s_tvalid & s_tready_s;

  // A new bit is taken only when the sample currently on the output retires.
  always_comb begin
    s_tready_s = 1'b0;
    if (i_rst) begin
      s_tready_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    s_tready_s = FILL_EN ? bus.i_m_tready : 1'b1;
        SEND:    s_tready_s = sym_last_s & bus.i_m_tready;
        default: s_tready_s = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    load_s     = 1'b0;
    adv_s      = 1'b0;
    if (s_hs_s) begin
      state_d    = SEND;
      bit_d      = bus.i_s_tdata;
      m_tvalid_d = 1'b1;
      m_tdata_d  = chip_val(4'd10, bus.i_s_tdata);
      m_tuser_d  = 1'b1;
      load_s     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          m_tvalid_d = FILL_EN;
          m_tdata_d  = 1'b0;
          m_tuser_d  = 1'b0;
        end
        SEND: begin
          adv_s = m_hs_s;
          if (m_hs_s && sym_last_s) begin
            state_d    = IDLE;
            m_tvalid_d = FILL_EN;
            m_tdata_d  = 1'b0;
            m_tuser_d  = 1'b0;
          end else if (m_hs_s && chip_last_s) begin
            m_tdata_d = chip_val(chip_idx_s - 4'd1, bit_q);
            m_tuser_d = 1'b0;
          end else begin
            m_tdata_d = m_tdata_q;
          end
        end
        default: begin
          state_d    = IDLE;
          m_tvalid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      bit_q      <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

  assign bus.o_s_tready = s_tready_s;
  assign bus.o_m_tvalid = m_tvalid_q;
  assign bus.o_m_tdata  = m_tdata_q;
  assign bus.o_m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_barker_tx.sv
// Directed bench for barker_tx; define BARKER_TX_IDLE_FILL_EN to also cover the idle fill stream.
module tb_barker_tx;

  localparam int OS = 4;
`ifdef BARKER_TX_IDLE_FILL_EN
  localparam logic IDLE_TV = 1'b1;
`else
  localparam logic IDLE_TV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Bit-1 sample stream, one hex digit per chip (chips 10..0 of 11100010010).
  logic [43:0] pat1 = 44'hFFF000F00F0;
  logic [43:0] pat0 = 44'h000FFF0FF0F;
  logic [15:0] stall_pat = 16'b1011_0001_1100_0111;
  logic [2:0]  b2b_bits = 3'b101;

  barker_tx_if bus();

  barker_tx #(.OVERSAMPLE(OS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic exp_bit(input logic b, input int j);
    return b ? pat1[43-j] : pat0[43-j];
  endfunction

  // Handshake one bit from IDLE, then check all 44 samples with i_m_tready high.
  task automatic send_sym(input logic b);
    bus.i_s_tvalid = 1'b1;
    bus.i_s_tdata  = b;
    check1("idle_tready", bus.o_s_tready, 1'b1);
    @(negedge clk);
    bus.i_s_tvalid = 1'b0;
    for (int j = 0; j < 44; j++) begin
      check1("sym_tvalid", bus.o_m_tvalid, 1'b1);
      check1("sym_tdata", bus.o_m_tdata, exp_bit(b, j));
      check1("sym_tuser", bus.o_m_tuser, (j < 4) ? 1'b1 : 1'b0);
      if (j == 0)  check1("first_tready", bus.o_s_tready, 1'b0);
      if (j == 43) check1("last_tready", bus.o_s_tready, 1'b1);
      @(negedge clk);
    end
    check1("end_tvalid", bus.o_m_tvalid, IDLE_TV);
    check1("end_tdata", bus.o_m_tdata, 1'b0);
  endtask

  initial begin
    int  nsent;
    int  sj;
    logic hs;

    bus.i_s_tvalid = 1'b0;
    bus.i_s_tdata  = 1'b0;
    bus.i_m_tready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_tvalid", bus.o_m_tvalid, 1'b0);
    check1("rst_tdata", bus.o_m_tdata, 1'b0);
    check1("rst_tuser", bus.o_m_tuser, 1'b0);
    check1("rst_tready", bus.o_s_tready, 1'b0);
    rst = 1'b0;
    #1;
    check1("rel_tready", bus.o_s_tready, 1'b1);
    @(negedge clk);
    check1("idle_tvalid", bus.o_m_tvalid, IDLE_TV);

    // Single symbols.
    send_sym(1'b1);
    send_sym(1'b0);

    // Back-to-back 1,0,1 with i_s_tvalid held high.
    nsent = 0;
    bus.i_s_tvalid = 1'b1;
    bus.i_s_tdata  = b2b_bits[2];
    for (int c = 0; c < 133; c++) begin
      if (c >= 1) begin
        check1("b2b_tvalid", bus.o_m_tvalid, 1'b1);
        check1("b2b_tdata", bus.o_m_tdata, exp_bit(b2b_bits[2 - (c-1)/44], (c-1) % 44));
        check1("b2b_tuser", bus.o_m_tuser, (((c-1) % 44) < 4) ? 1'b1 : 1'b0);
      end
      if (c < 132) check1("b2b_tready", bus.o_s_tready, (c % 44 == 0) ? 1'b1 : 1'b0);
      hs = bus.o_s_tready & bus.i_s_tvalid;
      @(posedge clk);
      #1;
      if (hs) begin
        nsent++;
        if (nsent == 3) bus.i_s_tvalid = 1'b0;
        else            bus.i_s_tdata  = b2b_bits[2 - nsent];
      end
      @(negedge clk);
    end
    check_int("b2b_count", nsent, 3);
    check1("b2b_end_tvalid", bus.o_m_tvalid, IDLE_TV);

    // Bit 0 with a fixed stall pattern on i_m_tready; each sample must hold until taken.
    bus.i_s_tvalid = 1'b1;
    bus.i_s_tdata  = 1'b0;
    @(negedge clk);
    bus.i_s_tvalid = 1'b0;
    sj = 0;
    for (int cyc = 0; cyc < 200 && sj < 44; cyc++) begin
      bus.i_m_tready = stall_pat[cyc % 16];
      check1("stall_tvalid", bus.o_m_tvalid, 1'b1);
      check1("stall_tdata", bus.o_m_tdata, exp_bit(1'b0, sj));
      check1("stall_tuser", bus.o_m_tuser, (sj < 4) ? 1'b1 : 1'b0);
      hs = bus.i_m_tready;
      @(posedge clk);
      if (hs) sj++;
      @(negedge clk);
    end
    check_int("stall_samples", sj, 44);
    bus.i_m_tready = 1'b1;
    @(negedge clk);
    check1("stall_end_tvalid", bus.o_m_tvalid, IDLE_TV);

    // Reset mid-symbol after 20 samples, then a clean restart at chip 10.
    bus.i_s_tvalid = 1'b1;
    bus.i_s_tdata  = 1'b1;
    @(negedge clk);
    bus.i_s_tvalid = 1'b0;
    repeat (20) @(negedge clk);
    check1("pre_rst_tvalid", bus.o_m_tvalid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("async_tvalid", bus.o_m_tvalid, 1'b0);
    check1("async_tdata", bus.o_m_tdata, 1'b0);
    check1("async_tuser", bus.o_m_tuser, 1'b0);
    check1("async_tready", bus.o_s_tready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("rel2_tready", bus.o_s_tready, 1'b1);
    @(negedge clk);
    send_sym(1'b1);

`ifdef BARKER_TX_IDLE_FILL_EN
    // Fill stream in IDLE, then a bit accepted only on a fill handshake.
    for (int k = 0; k < 10; k++) begin
      check1("fill_tvalid", bus.o_m_tvalid, 1'b1);
      check1("fill_tdata", bus.o_m_tdata, 1'b0);
      @(negedge clk);
    end
    bus.i_m_tready = 1'b0;
    bus.i_s_tvalid = 1'b1;
    bus.i_s_tdata  = 1'b1;
    check1("fill_stall_tready", bus.o_s_tready, 1'b0);
    @(negedge clk);
    check1("fill_hold_tvalid", bus.o_m_tvalid, 1'b1);
    check1("fill_hold_tuser", bus.o_m_tuser, 1'b0);
    bus.i_m_tready = 1'b1;
    check1("fill_tready", bus.o_s_tready, 1'b1);
    @(negedge clk);
    bus.i_s_tvalid = 1'b0;
    check1("fill_first_tdata", bus.o_m_tdata, 1'b1);
    check1("fill_first_tuser", bus.o_m_tuser, 1'b1);
    repeat (44) @(negedge clk);
    check1("fill_after_tdata", bus.o_m_tdata, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
